ahb_lsu_master_pipe: RTL and testbench
======================================

AHB_LSU_MASTER_PIPE -- requirements
Module: ahb_lsu_master_pipe

Interface
REQ-001 SHALL have parameter AW, default 32, meaning address width (>=12).
REQ-002 SHALL have parameter DEPTH, default 2, meaning request FIFO entries (power of 2, >=2).
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req_vld in 1, req_rdy out 1  LSU request handshake.
REQ-006 SHALL have ports req_wen in 1, req_rwtyp in 3, req_addr in AW, req_wdata in 32  request payload (rwtyp = RISC-V funct3).
REQ-007 SHALL have ports rsp_vld out 1, rsp_rdy in 1  LSU response handshake.
REQ-008 SHALL have ports rsp_rdata out 32, rsp_err out 1  response payload.
REQ-009 SHALL have outputs haddr AW, htrans 2, hwrite 1, hsize 3, hwdata 32, hbusreq 1  AHB master drive.
REQ-010 SHALL have inputs hgrant 1, hready 1, hresp 1, hrdata 32  AHB arbiter/slave returns.

Function
REQ-011 SHALL buffer requests in a DEPTH-entry FIFO; req_rdy = not full; push on req_vld&&req_rdy.
REQ-012 SHALL allow push and pop in the same cycle when full; occupancy unchanged, req_rdy stays 0 that cycle.
REQ-013 SHALL run FSM IDLE -> BUSREQ -> ADDR -> DATA -> RESP -> IDLE/BUSREQ; one outstanding transfer.
REQ-014 IDLE: leave when FIFO non-empty; hbusreq=0, htrans=IDLE(00).
REQ-015 BUSREQ: hbusreq=1; go to ADDR in the cycle after hgrant sampled 1; stay otherwise.
REQ-016 ADDR: htrans=NONSEQ(10), haddr/hwrite/hsize from FIFO head; leave on hready=1, popping head.
REQ-017 DATA: htrans=IDLE, hwdata valid for writes; wait while hready=0; on hready=1 capture hrdata, hresp.
REQ-018 RESP: rsp_vld=1 held until rsp_rdy; then BUSREQ if FIFO non-empty and hgrant=1 kept hbusreq, else IDLE.
REQ-019 hsize SHALL be {1'b0, rwtyp[1:0]}; rwtyp 011/110/111 SHALL be treated as word.
REQ-020 Writes: hwdata SHALL replicate byte (x4) or halfword (x2) across lanes; word passed as-is.
REQ-021 Reads: rsp_rdata SHALL select lane by addr[1:0], sign-extend if rwtyp[2]=0, zero-extend otherwise.
REQ-022 Writes SHALL return rsp_rdata=0; responses always issued for writes.
REQ-023 hresp=1 in DATA SHALL set rsp_err=1 and rsp_rdata=0; no retry.
REQ-024 Misaligned request (half at addr[0]=1, word at addr[1:0]!=0) SHALL skip the bus and go straight to RESP with rsp_err=1.
REQ-025 Minimum latency, granted, zero-wait slave: req accept cycle 0 -> rsp_vld cycle 4.
REQ-026 hbusreq SHALL deassert in RESP when FIFO will be empty.
REQ-027 All AHB outputs SHALL be registered.

Reset
REQ-028 On rstn=0: FSM=IDLE, FIFO empty, req_rdy=0 during reset then 1, rsp_vld=0, rsp_err=0, rsp_rdata=0, haddr=0, htrans=00, hwrite=0, hsize=0, hwdata=0, hbusreq=0.
REQ-029 Reset mid-transfer SHALL abort it; no response is produced for lost requests.

Structure
REQ-030 Shared package SHALL hold htrans encodings, hsize encodings, funct3 load/store constants, FSM state type.
REQ-031 FIFO SHALL be sub-module lsu_req_fifo (parameters WIDTH, DEPTH); lane/extension logic stays inline.

Verification
REQ-032 LW addr 0x100, hgrant=1, hready=1, hrdata=0xDEADBEEF -> htrans=10 haddr=0x100 hsize=010; rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_vld at cycle 4.
REQ-033 LB addr 0x103, hrdata=0x80112233 -> rsp_rdata=0xFFFFFF80; LBU same -> 0x00000080.
REQ-034 SH addr 0x202 wdata 0x0000ABCD -> hsize=001, hwdata=0xABCDABCD, hwrite=1.
REQ-035 DEPTH=2, hgrant=0, 3 back-to-back requests -> req_rdy=0 after 2; raise hgrant -> three responses in order.
REQ-036 hready=0 for 5 DATA cycles then hresp=1 -> rsp_err=1, rsp_rdata=0; LW addr 0x101 -> rsp_err=1, htrans never 10.
REQ-037 rstn pulsed low during DATA -> all outputs at reset values same cycle, FIFO empty, no rsp_vld after.

Source files
------------

// File: rtl/ahb_lsu_master_pipe_pkg.sv
// Shared definitions for the LSU-to-AHB master pipe: AHB transfer/size
// encodings, RISC-V load/store funct3 codes, FSM state type and helpers.
package ahb_lsu_master_pipe_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // funct3 of LB/LH/LW/LBU/LHU and SB/SH/SW
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BUSREQ,
        S_ADDR,
        S_DATA,
        S_RESP
    } state_t;

    // Size from funct3; the 64-bit encoding (x11) is folded onto word.
    function automatic logic [2:0] f3_hsize(input logic [2:0] f3);
        return (f3[1:0] == 2'b11) ? HSIZE_WORD : {1'b0, f3[1:0]};
    endfunction

    function automatic logic misaligned(input logic [2:0] sz, input logic [1:0] lo);
        return ((sz == HSIZE_HALF) && lo[0]) || ((sz == HSIZE_WORD) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_req_fifo.sv
// Request FIFO, DEPTH entries of WIDTH bits, first-word fall-through head.
// Ports: clk/rstn, push+wdata in, pop in, rdata (head) out, full/empty out.
// A push while full is taken only when a pop happens in the same cycle.
module lsu_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // Extra MSB on each pointer separates full from empty.
    logic [PW:0] wptr, rptr;
    logic        do_push, do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr[PW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[PW-1:0]] <= wdata;
    end

endmodule

// File: rtl/ahb_lsu_master_pipe.sv
// LSU load/store requests to a single-outstanding AHB master.
// Ports: req_* LSU request handshake + payload (rwtyp = funct3),
//        rsp_* LSU response handshake + read data/error,
//        h* AHB master outputs (all registered) and arbiter/slave returns.
module ahb_lsu_master_pipe
    import ahb_lsu_master_pipe_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          req_vld,
    output logic          req_rdy,
    input  logic          req_wen,
    input  logic [2:0]    req_rwtyp,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          rsp_vld,
    input  logic          rsp_rdy,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic [AW-1:0] haddr,
    output logic [1:0]    htrans,
    output logic          hwrite,
    output logic [2:0]    hsize,
    output logic [31:0]   hwdata,
    output logic          hbusreq,
    input  logic          hgrant,
    input  logic          hready,
    input  logic          hresp,
    input  logic [31:0]   hrdata
);
    localparam int FW = 1 + 3 + AW + 32;

    state_t        state;
    logic          rdy_en;     // holds req_rdy low until the first edge out of reset
    logic          push, pop, full, empty, pending;
    logic [FW-1:0] head;
    logic          h_wen, h_mis;
    logic [2:0]    h_typ, h_size;
    logic [AW-1:0] h_addr;
    logic [31:0]   h_wdata, wrep;
    logic          cur_wen;
    logic [2:0]    cur_typ;
    logic [1:0]    cur_lane;
    logic [7:0]    lbyte;
    logic [15:0]   lhalf;
    logic [31:0]   load_data;

    assign req_rdy = rdy_en && !full;
    assign push    = req_vld && req_rdy;
    // Work is available if the FIFO holds an entry or one lands this edge.
    assign pending = !empty || push;

    assign h_wen   = head[FW-1];
    assign h_typ   = head[FW-2 -: 3];
    assign h_addr  = head[32 +: AW];
    assign h_wdata = head[31:0];
    assign h_size  = f3_hsize(h_typ);
    assign h_mis   = misaligned(h_size, h_addr[1:0]);
    assign pop     = ((state == S_BUSREQ) && !empty && h_mis) || ((state == S_ADDR) && hready);

    lsu_req_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .wdata ({req_wen, req_rwtyp, req_addr, req_wdata}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    // Store data replicated across all byte lanes of the bus.
    always_comb begin
        case (h_size)
            HSIZE_BYTE: wrep = {4{h_wdata[7:0]}};
            HSIZE_HALF: wrep = {2{h_wdata[15:0]}};
            default:    wrep = h_wdata;
        endcase
    end

    // Load lane select and sign/zero extension of the captured transfer.
    assign lbyte = hrdata[{cur_lane, 3'b000} +: 8];
    assign lhalf = cur_lane[1] ? hrdata[31:16] : hrdata[15:0];
    always_comb begin
        case (f3_hsize(cur_typ))
            HSIZE_BYTE: load_data = cur_typ[2] ? {24'h0, lbyte} : {{24{lbyte[7]}}, lbyte};
            HSIZE_HALF: load_data = cur_typ[2] ? {16'h0, lhalf} : {{16{lhalf[15]}}, lhalf};
            default:    load_data = hrdata;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            rdy_en    <= 1'b0;
            rsp_vld   <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            haddr     <= '0;
            htrans    <= HTRANS_IDLE;
            hwrite    <= 1'b0;
            hsize     <= HSIZE_BYTE;
            hwdata    <= '0;
            hbusreq   <= 1'b0;
            cur_wen   <= 1'b0;
            cur_typ   <= F3_B;
            cur_lane  <= 2'b00;
        end else begin
            rdy_en <= 1'b1;
            case (state)
                S_IDLE: begin
                    htrans  <= HTRANS_IDLE;
                    hbusreq <= pending;
                    if (pending) state <= S_BUSREQ;
                end
                S_BUSREQ: begin
                    if (!empty && h_mis) begin
                        // Never reaches the bus: answer with an error directly.
                        state     <= S_RESP;
                        rsp_vld   <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        hbusreq   <= 1'b0;
                    end else if (hgrant) begin
                        state  <= S_ADDR;
                        htrans <= HTRANS_NONSEQ;
                        haddr  <= h_addr;
                        hwrite <= h_wen;
                        hsize  <= h_size;
                    end
                end
                S_ADDR: begin
                    if (hready) begin
                        state    <= S_DATA;
                        htrans   <= HTRANS_IDLE;
                        hwdata   <= h_wen ? wrep : 32'h0;
                        cur_wen  <= h_wen;
                        cur_typ  <= h_typ;
                        cur_lane <= h_addr[1:0];
                    end
                end
                S_DATA: begin
                    if (hready) begin
                        state     <= S_RESP;
                        rsp_vld   <= 1'b1;
                        rsp_err   <= hresp;
                        rsp_rdata <= (hresp || cur_wen) ? 32'h0 : load_data;
                        hbusreq   <= pending;
                    end
                end
                S_RESP: begin
                    hbusreq <= pending;
                    if (rsp_rdy) begin
                        rsp_vld <= 1'b0;
                        state   <= pending ? S_BUSREQ : S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_lsu_master_pipe.sv
module tb_ahb_lsu_master_pipe;

    typedef struct {
        logic        w;
        logic [2:0]  t;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;     // slave read data for this transfer
        logic        er;     // slave error for this transfer
        int          waits;  // slave wait states in the data phase
        int          acc;    // cycle the request was accepted
    } ent_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_vld, req_rdy, req_wen;
    logic [2:0]  req_rwtyp;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_vld, rsp_rdy, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] haddr, hwdata, hrdata;
    logic [1:0]  htrans;
    logic        hwrite, hbusreq, hgrant, hready, hresp;
    logic [2:0]  hsize;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   ns_cnt = 0;
    int   lat_last = 0;
    int   cur_w = 0;
    logic dpend = 0, dph = 0, seen_head = 0, hold = 0;
    bit   rdy_rand = 0;
    ent_t exp_q[$];
    ent_t bus_q[$];
    ent_t cur, pend_e;
    logic [31:0] last_rdata, last_hwdata;
    logic        last_err, last_hwrite;
    logic [2:0]  last_hsize;

    always #5 clk = ~clk;

    ahb_lsu_master_pipe #(.AW(32), .DEPTH(2)) dut (
        .clk(clk), .rstn(rstn),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_wen(req_wen),
        .req_rwtyp(req_rwtyp), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
        .hwdata(hwdata), .hbusreq(hbusreq),
        .hgrant(hgrant), .hready(hready), .hresp(hresp), .hrdata(hrdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // ---- reference model: access size in bytes, alignment, results ----
    function automatic int nb(input logic [2:0] t);
        return (t[1:0] == 2'b11) ? 4 : (1 << t[1:0]);
    endfunction

    function automatic logic mis(input ent_t e);
        return (int'(e.a[1:0]) % nb(e.t)) != 0;
    endfunction

    function automatic logic [2:0] exp_hsize(input ent_t e);
        return 3'($clog2(nb(e.t)));
    endfunction

    function automatic logic [31:0] exp_hwdata(input ent_t e);
        int n = nb(e.t);
        if (n == 1) return 32'(e.wd[7:0]) * 32'h01010101;
        if (n == 2) return 32'(e.wd[15:0]) * 32'h00010001;
        return e.wd;
    endfunction

    function automatic logic [32:0] exp_rsp(input ent_t e);
        int n = nb(e.t);
        logic [31:0] v, m;
        if (mis(e) || e.er) return {1'b1, 32'h0};
        if (e.w) return {1'b0, 32'h0};
        v = e.rd >> (8 * int'(e.a[1:0]));
        if (n < 4) begin
            m = (32'h1 << (8 * n)) - 32'h1;
            v = v & m;
            if (!e.t[2] && v[8 * n - 1]) v = v | ~m;
        end
        return {1'b0, v};
    endfunction

    function automatic ent_t mk(input logic w, input logic [2:0] t, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rd,
                                input logic er, input int waits);
        ent_t e;
        e.w = w; e.t = t; e.a = a; e.wd = wd; e.rd = rd; e.er = er; e.waits = waits; e.acc = 0;
        return e;
    endfunction

    // One clock cycle: act as slave, check bus/response, track acceptance.
    // Entered and left at 1 time unit after a rising edge.
    task automatic step();
        ent_t r;
        logic [32:0] ex;
        logic acc;
        if (dpend) begin dph = 1; dpend = 0; end
        if (dph) begin
            hrdata = cur.rd;
            if (cur_w > 0) begin
                hready = 0; hresp = 0; cur_w--;
            end else begin
                hready = 1; hresp = cur.er; dph = 0;
                last_hwdata = hwdata;
                if (cur.w) chk("hwdata", 64'(hwdata), 64'(exp_hwdata(cur)));
            end
        end else begin
            hready = 1; hresp = 0; hrdata = $urandom;
        end
        if (htrans == 2'b10) begin
            ns_cnt++;
            chk("nonseq_has_req", 64'(bus_q.size() > 0), 64'(1));
            if (bus_q.size() > 0) begin
                cur = bus_q.pop_front();
                cur_w = cur.waits;
                last_hsize = hsize; last_hwrite = hwrite;
                chk("haddr", 64'(haddr), 64'(cur.a));
                chk("hsize", 64'(hsize), 64'(exp_hsize(cur)));
                chk("hwrite", 64'(hwrite), 64'(cur.w));
                dpend = 1;
            end
        end
        if (hold) chk("rsp_hold", 64'(rsp_vld), 64'(1));
        rsp_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rsp_vld) begin
            chk("rsp_has_req", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
                if (!seen_head) begin lat_last = cyc - exp_q[0].acc; seen_head = 1; end
                if (rsp_rdy) begin
                    r = exp_q.pop_front();
                    ex = exp_rsp(r);
                    last_rdata = rsp_rdata; last_err = rsp_err;
                    chk("rsp_err", 64'(rsp_err), 64'(ex[32]));
                    chk("rsp_rdata", 64'(rsp_rdata), 64'(ex[31:0]));
                    seen_head = 0;
                end
            end
        end
        hold = rsp_vld && !rsp_rdy;
        acc = req_vld && req_rdy;
        if (acc) begin
            pend_e.acc = cyc;
            exp_q.push_back(pend_e);
            if (!mis(pend_e)) bus_q.push_back(pend_e);
        end
        @(posedge clk); #1;
        cyc++;
        if (acc) req_vld = 0;
    endtask

    task automatic submit(input ent_t e);
        pend_e = e;
        req_wen = e.w; req_rwtyp = e.t; req_addr = e.a; req_wdata = e.wd;
        req_vld = 1;
        for (int n = 0; n < 100 && req_vld; n++) step();
        chk("req_accepted", 64'(req_vld), 64'(0));
        req_vld = 0;
    endtask

    task automatic drain();
        for (int n = 0; n < 400 && (exp_q.size() > 0); n++) step();
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
        step();
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_req_rdy"}, 64'(req_rdy), 64'(0));
        chk({p, "_rsp_vld"}, 64'(rsp_vld), 64'(0));
        chk({p, "_rsp_err"}, 64'(rsp_err), 64'(0));
        chk({p, "_rsp_rdata"}, 64'(rsp_rdata), 64'(0));
        chk({p, "_haddr"}, 64'(haddr), 64'(0));
        chk({p, "_htrans"}, 64'(htrans), 64'(0));
        chk({p, "_hwrite"}, 64'(hwrite), 64'(0));
        chk({p, "_hsize"}, 64'(hsize), 64'(0));
        chk({p, "_hwdata"}, 64'(hwdata), 64'(0));
        chk({p, "_hbusreq"}, 64'(hbusreq), 64'(0));
    endtask

    initial begin
        int ns0;
        logic [2:0] ltyp [8];
        ltyp = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        rstn = 0; req_vld = 0; req_wen = 0; req_rwtyp = 0; req_addr = 0; req_wdata = 0;
        rsp_rdy = 0; hgrant = 1; hready = 1; hresp = 0; hrdata = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("rst");
        @(negedge clk) rstn = 1;
        @(posedge clk); #1;
        chk("rdy_after_reset", 64'(req_rdy), 64'(1));

        // LW, granted, zero-wait slave: minimum latency
        ns0 = ns_cnt;
        submit(mk(0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0));
        drain();
        chk("lw_nonseq", 64'(ns_cnt - ns0), 64'(1));
        chk("lw_hsize", 64'(last_hsize), 64'(3'b010));
        chk("lw_rdata", 64'(last_rdata), 64'(32'hDEADBEEF));
        chk("lw_err", 64'(last_err), 64'(0));
        chk("lw_latency", 64'(lat_last), 64'(4));

        // LB / LBU from the top byte lane
        submit(mk(0, 3'b000, 32'h103, 32'h0, 32'h80112233, 0, 0));
        drain();
        chk("lb_rdata", 64'(last_rdata), 64'(32'hFFFFFF80));
        submit(mk(0, 3'b100, 32'h103, 32'h0, 32'h80112233, 0, 0));
        drain();
        chk("lbu_rdata", 64'(last_rdata), 64'(32'h00000080));

        // SH: halfword replicated on the write bus
        submit(mk(1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 0, 0));
        drain();
        chk("sh_hsize", 64'(last_hsize), 64'(3'b001));
        chk("sh_hwrite", 64'(last_hwrite), 64'(1));
        chk("sh_hwdata", 64'(last_hwdata), 64'(32'hABCDABCD));
        chk("sh_rdata", 64'(last_rdata), 64'(0));

        // five wait states then slave error
        submit(mk(0, 3'b010, 32'h300, 32'h0, 32'h12345678, 1, 5));
        drain();
        chk("herr_err", 64'(last_err), 64'(1));
        chk("herr_rdata", 64'(last_rdata), 64'(0));

        // misaligned word never reaches the bus
        ns0 = ns_cnt;
        submit(mk(0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0));
        drain();
        chk("mis_err", 64'(last_err), 64'(1));
        chk("mis_no_nonseq", 64'(ns_cnt - ns0), 64'(0));

        // no grant: FIFO fills after two, then three responses in order
        hgrant = 0;
        submit(mk(0, 3'b010, 32'h400, 32'h0, 32'h11111111, 0, 0));
        submit(mk(0, 3'b001, 32'h402, 32'h0, 32'h8765_0000, 0, 1));
        pend_e = mk(0, 3'b101, 32'h404, 32'h0, 32'h0000_F00D, 0, 0);
        req_wen = 0; req_rwtyp = 3'b101; req_addr = 32'h404; req_wdata = 0; req_vld = 1;
        for (int i = 0; i < 3; i++) begin
            chk("full_rdy_low", 64'(req_rdy), 64'(0));
            chk("full_busreq", 64'(hbusreq), 64'(1));
            step();
        end
        hgrant = 1;
        for (int n = 0; n < 100 && req_vld; n++) step();
        chk("third_accepted", 64'(req_vld), 64'(0));
        req_vld = 0;
        drain();

        // randomized mix, random response back-pressure, some overlap
        rdy_rand = 1;
        for (int i = 0; i < 30; i++) begin
            logic w;
            logic [2:0] t;
            w = 1'($urandom_range(0, 1));
            t = w ? 3'($urandom_range(0, 2)) : ltyp[$urandom_range(0, 7)];
            submit(mk(w, t, $urandom, $urandom, $urandom, ($urandom_range(0, 7) == 0),
                      int'($urandom_range(0, 2))));
            if ($urandom_range(0, 1) == 1) drain();
        end
        drain();
        rdy_rand = 0;

        // reset in the middle of a data phase
        submit(mk(0, 3'b010, 32'h500, 32'h0, 32'hCAFEF00D, 0, 8));
        for (int n = 0; n < 20 && !dph; n++) step();
        chk("reached_data", 64'(dph), 64'(1));
        rstn = 0;
        #1;
        chk_reset("midrst");
        exp_q.delete(); bus_q.delete();
        dph = 0; dpend = 0; seen_head = 0; hold = 0; hready = 1; hresp = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rstn = 1;
        @(posedge clk); #1;
        chk("rdy_after_midrst", 64'(req_rdy), 64'(1));
        ns0 = ns_cnt;
        for (int i = 0; i < 10; i++) begin
            chk("no_rsp_after_rst", 64'(rsp_vld), 64'(0));
            step();
        end
        chk("no_bus_after_rst", 64'(ns_cnt - ns0), 64'(0));
        submit(mk(0, 3'b001, 32'h602, 32'h0, 32'h7FFF_0000, 0, 0));
        drain();
        chk("post_rst_lh", 64'(last_rdata), 64'(32'h00007FFF));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
